banco_nos_ativos: RTL and testbench

Register bank holding the active-node (NA) slots of the path-search engine, sitting directly downstream of `gerenciador_ativos`. It applies that block's one-hot slot writes and deactivations, and feeds `na_endereco`/`na_ativo` back to it. On request it runs a sequential scan for the active node of minimum cost, which the expansion stage consumes next.

---
 rtl/banco_nos_ativos.sv | 186 ++++++++++++++++++
 tb/tb_banco_nos_ativos.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banco_nos_ativos.sv
// banco_nos_ativos: register bank of the active-node (NA) slots.
// Takes one-hot slot writes/deactivations from gerenciador_ativos, exposes the
// slot addresses and active flags back to it, and on request scans all slots
// sequentially (one per cycle) for the active node of minimum cost.
// Optional feature: define BANCO_NA_REMOVE_MENOR_EN to clear the winner's
// active flag in the strobe cycle (search-and-pop).
module banco_nos_ativos #(
    parameter int NUM_NA      = 8,
    parameter int ADR_WIDTH   = 5,
    parameter int CUSTO_WIDTH = 8,
    localparam int IDX_W      = $clog2(NUM_NA)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ga_atualizar_in,
    input  logic                          ga_desativar_in,
    input  logic [NUM_NA-1:0]             ga_habilitar_in,
    input  logic [ADR_WIDTH-1:0]          ga_endereco_in,
    input  logic [ADR_WIDTH-1:0]          ga_anterior_in,
    input  logic [CUSTO_WIDTH-1:0]        custo_in,
    input  logic                          menor_req_in,
    output logic [ADR_WIDTH*NUM_NA-1:0]   na_endereco_out,
    output logic [NUM_NA-1:0]             na_ativo_out,
    output logic                          na_cheio_out,
    output logic                          ocupado_out,
    output logic                          menor_valido_out,
    output logic                          menor_vazio_out,
    output logic [ADR_WIDTH-1:0]          menor_endereco_out,
    output logic [ADR_WIDTH-1:0]          menor_anterior_out,
    output logic [CUSTO_WIDTH-1:0]        menor_custo_out,
    output logic [IDX_W-1:0]              menor_indice_out
);

    typedef enum logic [1:0] {ST_IDLE, ST_VARRE, ST_FIM} estado_t;

    localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(NUM_NA - 1);

    // Slot storage
    logic [ADR_WIDTH-1:0]   endereco_q [NUM_NA];
    logic [ADR_WIDTH-1:0]   anterior_q [NUM_NA];
    logic [CUSTO_WIDTH-1:0] custo_q    [NUM_NA];
    logic [NUM_NA-1:0]      ativo_q;

    // Search state and minimum tracker
    estado_t                state_q, state_d;
    logic [IDX_W-1:0]       indice_q;
    logic                   melhor_valido_q;
    logic [ADR_WIDTH-1:0]   melhor_endereco_q, melhor_anterior_q;
    logic [CUSTO_WIDTH-1:0] melhor_custo_q;
    logic [IDX_W-1:0]       melhor_indice_q;

    // Tracker value after considering the slot under the scan index
    logic                   candidato;
    logic                   prox_valido;
    logic [ADR_WIDTH-1:0]   prox_endereco, prox_anterior;
    logic [CUSTO_WIDTH-1:0] prox_custo;
    logic [IDX_W-1:0]       prox_indice;

    // Slot registers: manager writes/deactivates, plus optional pop of the winner
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the slot array is reset explicitly because its contents are
            // architecturally visible on na_endereco_out from reset onward.
            for (int i = 0; i < NUM_NA; i++) begin
                endereco_q[i] <= '0;
                anterior_q[i] <= '0;
                custo_q[i]    <= '0;
            end
            ativo_q <= '0;
        end else begin
`ifdef BANCO_NA_REMOVE_MENOR_EN
            // Placed before the manager loop so a manager op on the same slot wins.
            if (state_q == ST_FIM && !menor_vazio_out)
                ativo_q[menor_indice_out] <= 1'b0;
`endif
            for (int i = 0; i < NUM_NA; i++) begin
                if (ga_habilitar_in[i]) begin
                    if (ga_desativar_in) begin
                        ativo_q[i] <= 1'b0;
                    end else if (ga_atualizar_in) begin
                        endereco_q[i] <= ga_endereco_in;
                        anterior_q[i] <= ga_anterior_in;
                        custo_q[i]    <= custo_in;
                        ativo_q[i]    <= 1'b1;
                    end
                end
            end
        end
    end

    // Pack slot addresses and derive the full flag
    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        na_endereco_out = '0;
        for (int i = 0; i < NUM_NA; i++)
            na_endereco_out[ADR_WIDTH*i +: ADR_WIDTH] = endereco_q[i];
    end

    assign na_ativo_out = ativo_q;
    assign na_cheio_out = &ativo_q;
    assign ocupado_out  = (state_q != ST_IDLE);

    // Compare the live slot at the scan index against the current best (strict <)
    always_comb begin
        candidato     = ativo_q[indice_q] &&
                        (!melhor_valido_q || (custo_q[indice_q] < melhor_custo_q));
        prox_valido   = melhor_valido_q;
        prox_endereco = melhor_endereco_q;
        prox_anterior = melhor_anterior_q;
        prox_custo    = melhor_custo_q;
        prox_indice   = melhor_indice_q;
        if (candidato) begin
            prox_valido   = 1'b1;
            prox_endereco = endereco_q[indice_q];
            prox_anterior = anterior_q[indice_q];
            prox_custo    = custo_q[indice_q];
            prox_indice   = indice_q;
        end
    end

    // Search FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (menor_req_in) state_d = ST_VARRE;
            ST_VARRE: if (indice_q == ULTIMO) state_d = ST_FIM;
            ST_FIM:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Search FSM state, scan index, tracker and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= ST_IDLE;
            indice_q           <= '0;
            melhor_valido_q    <= 1'b0;
            melhor_endereco_q  <= '0;
            melhor_anterior_q  <= '0;
            melhor_custo_q     <= '0;
            melhor_indice_q    <= '0;
            menor_valido_out   <= 1'b0;
            menor_vazio_out    <= 1'b0;
            menor_endereco_out <= '0;
            menor_anterior_out <= '0;
            menor_custo_out    <= '0;
            menor_indice_out   <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            state_q          <= state_d;
            menor_valido_out <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (menor_req_in) begin
                        indice_q          <= '0;
                        melhor_valido_q   <= 1'b0;
                        melhor_endereco_q <= '0;
                        melhor_anterior_q <= '0;
                        melhor_custo_q    <= '0;
                        melhor_indice_q   <= '0;
                    end
                end
                ST_VARRE: begin
                    melhor_valido_q   <= prox_valido;
                    melhor_endereco_q <= prox_endereco;
                    melhor_anterior_q <= prox_anterior;
                    melhor_custo_q    <= prox_custo;
                    melhor_indice_q   <= prox_indice;
                    indice_q          <= indice_q + 1'b1;
                    if (indice_q == ULTIMO) begin
                        // Tracker fields are zero when nothing was captured.
                        menor_valido_out   <= 1'b1;
                        menor_vazio_out    <= !prox_valido;
                        menor_endereco_out <= prox_endereco;
                        menor_anterior_out <= prox_anterior;
                        menor_custo_out    <= prox_custo;
                        menor_indice_out   <= prox_indice;
                    end
                end
                ST_FIM: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_banco_nos_ativos.sv
// Self-checking bench for banco_nos_ativos: table-driven slot operations,
// hand-written search corner cases and randomized traffic against a model.
module tb_banco_nos_ativos;

    localparam int N  = 8;
    localparam int AW = 5;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ga_atualizar, ga_desativar;
    logic [N-1:0]  ga_habilitar;
    logic [AW-1:0] ga_endereco, ga_anterior;
    logic [CW-1:0] custo;
    logic          menor_req;
    logic [AW*N-1:0] na_endereco;
    logic [N-1:0]  na_ativo;
    logic          na_cheio, ocupado, menor_valido, menor_vazio;
    logic [AW-1:0] menor_endereco, menor_anterior;
    logic [CW-1:0] menor_custo;
    logic [2:0]    menor_indice;

    banco_nos_ativos dut (
        .clk                (clk),
        .rst                (rst),
        .ga_atualizar_in    (ga_atualizar),
        .ga_desativar_in    (ga_desativar),
        .ga_habilitar_in    (ga_habilitar),
        .ga_endereco_in     (ga_endereco),
        .ga_anterior_in     (ga_anterior),
        .custo_in           (custo),
        .menor_req_in       (menor_req),
        .na_endereco_out    (na_endereco),
        .na_ativo_out       (na_ativo),
        .na_cheio_out       (na_cheio),
        .ocupado_out        (ocupado),
        .menor_valido_out   (menor_valido),
        .menor_vazio_out    (menor_vazio),
        .menor_endereco_out (menor_endereco),
        .menor_anterior_out (menor_anterior),
        .menor_custo_out    (menor_custo),
        .menor_indice_out   (menor_indice)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] endereco;
        logic [AW-1:0] anterior;
        logic [CW-1:0] custo;
        bit            ativo;
    } slot_t;

    slot_t modelo [N];

    typedef struct {
        logic [N-1:0]  hab;
        logic          atu;
        logic          des;
        logic [AW-1:0] ende;
        logic [AW-1:0] ant;
        logic [CW-1:0] custo;
        logic [N-1:0]  exp_ativo;
        logic          exp_cheio;
    } vetor_t;

    vetor_t tabela [10];

    task automatic check(input string nome, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] modelo_ativo();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = modelo[i].ativo;
        return v;
    endfunction

    function automatic logic [AW*N-1:0] modelo_enderecos();
        logic [AW*N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[AW*i +: AW] = modelo[i].endereco;
        return v;
    endfunction

    // Drive a manager operation for the current cycle and record its effect.
    task automatic drive_ga(input logic [N-1:0] hab, input logic atu, input logic des,
                            input logic [AW-1:0] e, input logic [AW-1:0] a, input logic [CW-1:0] c);
        ga_habilitar = hab; ga_atualizar = atu; ga_desativar = des;
        ga_endereco = e; ga_anterior = a; custo = c;
        for (int i = 0; i < N; i++) begin
            if (hab[i]) begin
                if (des) modelo[i].ativo = 1'b0;
                else if (atu) modelo[i] = '{e, a, c, 1'b1};
            end
        end
    endtask

    task automatic clear_ga();
        ga_habilitar = '0; ga_atualizar = 1'b0; ga_desativar = 1'b0;
        ga_endereco = '0; ga_anterior = '0; custo = '0;
    endtask

    task automatic ga_op(input logic [N-1:0] hab, input logic atu, input logic des,
                         input logic [AW-1:0] e, input logic [AW-1:0] a, input logic [CW-1:0] c);
        drive_ga(hab, atu, des, e, a, c);
        tick();
        clear_ga();
    endtask

    task automatic check_bank(input string nome);
        check({nome, "_ativo"}, na_ativo, modelo_ativo());
        check({nome, "_end"}, na_endereco, modelo_enderecos());
        check({nome, "_cheio"}, na_cheio, &modelo_ativo());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) modelo[i] = '{'0, '0, '0, 1'b0};
    endtask

    // Reference: find the minimum cost over active observed slots, then the
    // lowest index holding it.
    task automatic ref_min(input slot_t s [N], output bit vazio, output int idx);
        int minc = 1 << CW;
        vazio = 1'b1;
        idx = 0;
        for (int i = 0; i < N; i++)
            if (s[i].ativo && int'(s[i].custo) < minc) minc = int'(s[i].custo);
        for (int i = N - 1; i >= 0; i--) begin
            if (s[i].ativo && int'(s[i].custo) == minc) begin
                vazio = 1'b0;
                idx = i;
            end
        end
    endtask

    // Launch a search; optionally a second req at tick req2_at, a manager write
    // at tick wr_at, and a req during the strobe cycle. Each slot is recorded as
    // the scan sees it (the model state visible in the cycle it is scanned).
    task automatic run_search(input string nome, input int req2_at, input int wr_at,
                              input logic [N-1:0] wr_hab, input logic [CW-1:0] wr_custo,
                              input bit req_in_strobe, output int strobe_at);
        slot_t snap [N];
        bit vazio;
        int idx;
        logic [AW-1:0] e_end, e_ant;
        logic [CW-1:0] e_custo;
        menor_req = 1'b1;
        tick();
        menor_req = 1'b0;
        strobe_at = -1;
        for (int k = 1; k <= 20; k++) begin
            clear_ga();
            menor_req = 1'b0;
            if (k <= N) snap[k-1] = modelo[k-1];
            check({nome, "_ocupado"}, ocupado, k <= N + 1);
            if (menor_valido) begin
                strobe_at = k;
                break;
            end
            if (k == req2_at) menor_req = 1'b1;
            if (k == wr_at) drive_ga(wr_hab, 1'b1, 1'b0, 5'd31, 5'd30, wr_custo);
            tick();
        end
        check({nome, "_strobe_at"}, 64'(strobe_at), 64'(N + 1));
        ref_min(snap, vazio, idx);
        e_end   = vazio ? '0 : snap[idx].endereco;
        e_ant   = vazio ? '0 : snap[idx].anterior;
        e_custo = vazio ? '0 : snap[idx].custo;
        if (vazio) idx = 0;
        check({nome, "_vazio"}, menor_vazio, vazio);
        check({nome, "_indice"}, menor_indice, idx);
        check({nome, "_endereco"}, menor_endereco, e_end);
        check({nome, "_anterior"}, menor_anterior, e_ant);
        check({nome, "_custo"}, menor_custo, e_custo);
`ifdef BANCO_NA_REMOVE_MENOR_EN
        if (!vazio) modelo[idx].ativo = 1'b0;
`endif
        menor_req = req_in_strobe;
        tick();
        menor_req = 1'b0;
        check({nome, "_strobe_off"}, menor_valido, 1'b0);
        check({nome, "_idle"}, ocupado, 1'b0);
        check({nome, "_hold_custo"}, menor_custo, e_custo);
        check({nome, "_hold_indice"}, menor_indice, idx);
        check_bank({nome, "_post"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst = 1'b1;
        menor_req = 1'b0;
        clear_ga();

        // Cumulative slot operations from reset.
        tabela[0] = '{8'h04, 1'b1, 1'b0, 5'd5,  5'd1, 8'd40, 8'h04, 1'b0};
        tabela[1] = '{8'h00, 1'b1, 1'b0, 5'd7,  5'd7, 8'd7,  8'h04, 1'b0};
        tabela[2] = '{8'h00, 1'b1, 1'b0, 5'd7,  5'd7, 8'd7,  8'h04, 1'b0};
        tabela[3] = '{8'h04, 1'b1, 1'b1, 5'd9,  5'd9, 8'd9,  8'h00, 1'b0};
        tabela[4] = '{8'h12, 1'b1, 1'b0, 5'd9,  5'd2, 8'd20, 8'h12, 1'b0};
        tabela[5] = '{8'h01, 1'b0, 1'b0, 5'd3,  5'd3, 8'd3,  8'h12, 1'b0};
        tabela[6] = '{8'h10, 1'b0, 1'b1, 5'd0,  5'd0, 8'd0,  8'h02, 1'b0};
        tabela[7] = '{8'hFF, 1'b1, 1'b0, 5'd3,  5'd4, 8'd7,  8'hFF, 1'b1};
        tabela[8] = '{8'h80, 1'b0, 1'b1, 5'd0,  5'd0, 8'd0,  8'h7F, 1'b0};
        tabela[9] = '{8'h80, 1'b1, 1'b0, 5'd12, 5'd6, 8'd2,  8'hFF, 1'b1};

        do_reset();
        check("rst_ativo", na_ativo, 8'h00);
        check("rst_end", na_endereco, '0);
        check("rst_cheio", na_cheio, 1'b0);
        check("rst_ocupado", ocupado, 1'b0);
        check("rst_valido", menor_valido, 1'b0);
        check("rst_fields", {menor_vazio, menor_endereco, menor_anterior, menor_custo, menor_indice}, '0);

        for (int i = 0; i < 10; i++) begin
            ga_op(tabela[i].hab, tabela[i].atu, tabela[i].des,
                  tabela[i].ende, tabela[i].ant, tabela[i].custo);
            check($sformatf("tab%0d_ativo", i), na_ativo, tabela[i].exp_ativo);
            check($sformatf("tab%0d_cheio", i), na_cheio, tabela[i].exp_cheio);
            check($sformatf("tab%0d_end", i), na_endereco, modelo_enderecos());
            if (i == 3) check("tab_slot2_kept", na_endereco[14:10], 5'd5);
        end

        // Minimum search with a tie (lowest index wins) and an ignored mid-search req.
        do_reset();
        ga_op(8'h02, 1'b1, 1'b0, 5'd11, 5'd1, 8'd30);
        ga_op(8'h10, 1'b1, 1'b0, 5'd14, 5'd4, 8'd12);
        ga_op(8'h40, 1'b1, 1'b0, 5'd16, 5'd6, 8'd12);
        run_search("min3", 3, -1, '0, '0, 1'b0, s);
        check("min3_indice4", menor_indice, 3'd4);
        check("min3_custo12", menor_custo, 8'd12);

        // Empty bank; req in the strobe cycle is ignored, next cycle accepted.
        do_reset();
        run_search("vazio", -1, -1, '0, '0, 1'b1, s);
        check("vazio_flag", menor_vazio, 1'b1);
        run_search("b2b", -1, -1, '0, '0, 1'b0, s);

        // Write to an already-scanned slot during the search is not seen.
        do_reset();
        ga_op(8'h08, 1'b1, 1'b0, 5'd8, 5'd3, 8'd50);
        ga_op(8'h20, 1'b1, 1'b0, 5'd10, 5'd5, 8'd60);
        run_search("late_wr", -1, 5, 8'h01, 8'd1, 1'b0, s);
        check("late_wr_indice", menor_indice, 3'd3);
        // Write ahead of the scan index is seen.
        run_search("early_wr", -1, 2, 8'h40, 8'd5, 1'b0, s);

        // Full bank, then reset mid-search aborts everything.
        do_reset();
        for (int i = 0; i < N; i++) ga_op(N'(1) << i, 1'b1, 1'b0, AW'(i + 1), AW'(i), CW'(100 - i));
        check("cheio", na_cheio, 1'b1);
        menor_req = 1'b1;
        tick();
        menor_req = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) modelo[i] = '{'0, '0, '0, 1'b0};
        check("abort_ocupado", ocupado, 1'b0);
        check_bank("abort");
        check("abort_fields", {menor_valido, menor_vazio, menor_endereco, menor_anterior,
                               menor_custo, menor_indice}, '0);
        begin
            int strobes = 0;
            for (int k = 0; k < 12; k++) begin
                if (menor_valido) strobes++;
                tick();
            end
            check("abort_no_strobe", 64'(strobes), 64'(0));
        end

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            int nops = $urandom_range(1, 5);
            for (int j = 0; j < nops; j++) begin
                logic [N-1:0] hab;
                logic des;
                hab = ($urandom_range(0, 5) == 0) ? N'($urandom) : (N'(1) << $urandom_range(0, N - 1));
                des = ($urandom_range(0, 3) == 0);
                ga_op(hab, 1'($urandom), des, AW'($urandom), AW'($urandom), CW'($urandom_range(0, 15)));
                check_bank($sformatf("rnd%0d_op", it));
            end
            run_search($sformatf("rnd%0d", it),
                       ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1,
                       ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 8)) : -1,
                       N'(1) << $urandom_range(0, N - 1), CW'($urandom_range(0, 15)),
                       1'b0, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
